// File: rtl/rr_arb_mux_4_1_if.sv
// Handshake bundle for the 4:1 round-robin arbitrating mux.
// Four requester ports in, one registered output port out.
interface rr_arb_mux_4_1_if #(
  parameter int W = 4
);
  logic [3:0]   vld;
  logic [W-1:0] d0;
  logic [W-1:0] d1;
  logic [W-1:0] d2;
  logic [W-1:0] d3;
  logic [3:0]   rdy;
  logic         out_vld;
  logic         out_rdy;
  logic [W-1:0] y;
  logic [1:0]   sel;

  modport master (
    output vld, d0, d1, d2, d3, out_rdy,
    input  rdy, out_vld, y, sel
  );

  modport slave (
    input  vld, d0, d1, d2, d3, out_rdy,
    output rdy, out_vld, y, sel
  );
endinterface

// File: rtl/rr_arb_mux_4_1.sv
// Round-robin 4:1 arbiter feeding a single registered output slot.
// Grant scans upward from ptr; slot refills in the cycle it drains.
module rr_arb_mux_4_1 #(
  parameter int W = 4
) (
  input logic             clk,
  input logic             rst,
  rr_arb_mux_4_1_if.slave bus
);

  logic [1:0]   ptr;
  logic         ov;
  logic [W-1:0] yq;
  logic [1:0]   sq;

  logic         free;
  logic         gnt_v;
  logic [1:0]   gnt;
  logic [1:0]   idx;
  logic         take;
  logic [W-1:0] dmux;

  assign free = !ov || bus.out_rdy;
  assign take = free && gnt_v && !rst;

  // First valid requester at or above ptr, wrapping; lowest offset wins.
  always_comb begin
    gnt_v = 1'b0;
    gnt   = ptr;
    idx   = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (bus.vld[idx]) begin
        gnt_v = 1'b1;
        gnt   = idx;
      end
    end
  end

  // Payload select driven only by the granted index.
  always_comb begin
    dmux = '0;
    unique case (gnt)
      2'd0: dmux = bus.d0;
      2'd1: dmux = bus.d1;
      2'd2: dmux = bus.d2;
      2'd3: dmux = bus.d3;
    endcase
  end

  assign bus.rdy     = take ? (4'b0001 << gnt) : 4'b0000;
  assign bus.out_vld = ov;
  assign bus.y       = yq;
  assign bus.sel     = sq;

  // Output slot: load on grant, clear on drain without refill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ov  <= 1'b0;
      yq  <= '0;
      sq  <= 2'd0;
      ptr <= 2'd0;
    end else if (take) begin
      ov  <= 1'b1;
      yq  <= dmux;
      sq  <= gnt;
      ptr <= gnt + 2'd1;
    end else if (ov && bus.out_rdy) begin
      ov  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_arb_mux_4_1.sv
// Bench for rr_arb_mux_4_1: directed table, hand sequences,
// then random traffic against a queue-free round-robin model.
module tb_rr_arb_mux_4_1;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  rr_arb_mux_4_1_if #(.W(W)) bus ();

  rr_arb_mux_4_1 #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference state: pointer, slot valid, held word and index.
  int           m_ptr;
  bit           m_ov;
  logic [W-1:0] m_y;
  int           m_sel;

  typedef struct {
    logic [3:0] v;
    logic       r;
    logic [3:0] er;
    logic       ev;
    logic [3:0] ey;
    logic [1:0] es;
  } vec_t;

  vec_t tab[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [W-1:0] din(input int i);
    case (i)
      0: return bus.d0;
      1: return bus.d1;
      2: return bus.d2;
      default: return bus.d3;
    endcase
  endfunction

  function automatic int m_grant();
    if (rst) return -1;
    if (m_ov && !bus.out_rdy) return -1;
    for (int i = 0; i < 4; i++) begin
      int j;
      j = (m_ptr + i) % 4;
      if (bus.vld[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [3:0] m_rdy();
    int g;
    g = m_grant();
    return (g < 0) ? 4'b0000 : 4'(1 << g);
  endfunction

  task automatic m_edge();
    int g;
    g = m_grant();
    if (g >= 0) begin
      m_y   = din(g);
      m_sel = g;
      m_ov  = 1'b1;
      m_ptr = (g + 1) % 4;
    end else if (m_ov && bus.out_rdy) begin
      m_ov = 1'b0;
    end
  endtask

  task automatic m_reset();
    m_ptr = 0;
    m_ov  = 1'b0;
    m_y   = '0;
    m_sel = 0;
  endtask

  task automatic drive(input logic [3:0] v, input logic r);
    bus.vld     = v;
    bus.out_rdy = r;
  endtask

  task automatic set_d(input logic [W-1:0] a, b, c, e);
    bus.d0 = a;
    bus.d1 = b;
    bus.d2 = c;
    bus.d3 = e;
  endtask

  // One model-checked cycle with inputs already driven.
  task automatic mcycle(input string nm);
    #1;
    chk({nm, ".rdy"}, 32'(bus.rdy), 32'(m_rdy()));
    @(posedge clk);
    m_edge();
    #1;
    chk({nm, ".ov"}, 32'(bus.out_vld), 32'(m_ov));
    if (m_ov) begin
      chk({nm, ".y"}, 32'(bus.y), 32'(m_y));
      chk({nm, ".sel"}, 32'(bus.sel), 32'(m_sel));
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(4'b1111, 1'b1);
    m_reset();
    #1;
    chk("rst.rdy", 32'(bus.rdy), 32'd0);
    chk("rst.ov", 32'(bus.out_vld), 32'd0);
    chk("rst.y", 32'(bus.y), 32'd0);
    chk("rst.sel", 32'(bus.sel), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(4'b0000, 1'b1);
  endtask

  initial begin
    logic [3:0] v;
    drive(4'b0000, 1'b1);
    set_d(4'ha, 4'hb, 4'hc, 4'hd);
    m_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_reset();

    // single request, then steer ptr to 0
    tab.push_back('{4'b0100, 1'b1, 4'b0100, 1'b1, 4'hc, 2'd2});
    tab.push_back('{4'b1000, 1'b1, 4'b1000, 1'b1, 4'hd, 2'd3});
    // all requesting: a b c d a
    tab.push_back('{4'b1111, 1'b1, 4'b0001, 1'b1, 4'ha, 2'd0});
    tab.push_back('{4'b1111, 1'b1, 4'b0010, 1'b1, 4'hb, 2'd1});
    tab.push_back('{4'b1111, 1'b1, 4'b0100, 1'b1, 4'hc, 2'd2});
    tab.push_back('{4'b1111, 1'b1, 4'b1000, 1'b1, 4'hd, 2'd3});
    tab.push_back('{4'b1111, 1'b1, 4'b0001, 1'b1, 4'ha, 2'd0});
    // backpressure holds a, then drain+refill gives b
    tab.push_back('{4'b1111, 1'b0, 4'b0000, 1'b1, 4'ha, 2'd0});
    tab.push_back('{4'b1111, 1'b0, 4'b0000, 1'b1, 4'ha, 2'd0});
    tab.push_back('{4'b1111, 1'b0, 4'b0000, 1'b1, 4'ha, 2'd0});
    tab.push_back('{4'b1111, 1'b1, 4'b0010, 1'b1, 4'hb, 2'd1});
    // grant 2 -> ptr 3, then skip/wrap over 0011
    tab.push_back('{4'b0100, 1'b1, 4'b0100, 1'b1, 4'hc, 2'd2});
    tab.push_back('{4'b0011, 1'b1, 4'b0001, 1'b1, 4'ha, 2'd0});
    tab.push_back('{4'b0011, 1'b1, 4'b0010, 1'b1, 4'hb, 2'd1});
    tab.push_back('{4'b0011, 1'b1, 4'b0001, 1'b1, 4'ha, 2'd0});
    // drain without refill, then idle
    tab.push_back('{4'b0000, 1'b1, 4'b0000, 1'b0, 4'ha, 2'd0});
    tab.push_back('{4'b0000, 1'b1, 4'b0000, 1'b0, 4'ha, 2'd0});

    foreach (tab[i]) begin
      drive(tab[i].v, tab[i].r);
      #1;
      chk($sformatf("tab%0d.rdy", i), 32'(bus.rdy), 32'(tab[i].er));
      @(posedge clk);
      m_edge();
      #1;
      chk($sformatf("tab%0d.ov", i), 32'(bus.out_vld), 32'(tab[i].ev));
      chk($sformatf("tab%0d.y", i), 32'(bus.y), 32'(tab[i].ey));
      chk($sformatf("tab%0d.sel", i), 32'(bus.sel), 32'(tab[i].es));
      @(negedge clk);
    end

    // reset mid-stall drops out_vld with no clock edge
    drive(4'b0001, 1'b0);
    mcycle("stall.fill");
    drive(4'b1111, 1'b0);
    mcycle("stall.hold");
    rst = 1'b1;
    m_reset();
    #1;
    chk("midrst.ov", 32'(bus.out_vld), 32'd0);
    chk("midrst.rdy", 32'(bus.rdy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(4'b1010, 1'b1);
    #1;
    chk("postrst.rdy", 32'(bus.rdy), 32'b0010);
    mcycle("postrst");

    // unknown payload on a never-granted requester
    set_d(4'h1, 4'h2, 4'h3, 4'bxxxx);
    drive(4'b0111, 1'b1);
    for (int i = 0; i < 6; i++) begin
      mcycle($sformatf("xiso%0d", i));
      chk($sformatf("xiso%0d.known", i), 32'($isunknown(bus.y)), 32'd0);
      chk($sformatf("xiso%0d.not3", i), 32'(bus.sel == 2'd3), 32'd0);
    end

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      set_d(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      v = 4'($urandom_range(0, 15));
      drive(v, $urandom_range(0, 3) != 0);
      mcycle($sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_arb_mux_4_1.md
RR_ARB_MUX_4_1 -- requirements
Module: rr_arb_mux_4_1

Interface
REQ-001 Parameter: W, default 4, data width of every requester and of the output.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 vld  input  4  requester valid; bit i belongs to requester i.
REQ-005 d0, d1, d2, d3  input  W each  requester payloads.
REQ-006 rdy  output  4  per-requester accept; one-hot or zero.
REQ-007 out_vld  output  1  output register holds a valid word.
REQ-008 out_rdy  input  1  downstream accepts the output word.
REQ-009 y  output  W  registered payload of the granted requester.
REQ-010 sel  output  2  registered index of the requester whose payload is in y.

Function
REQ-011 Transfer rules: an input transfer on requester i occurs when vld[i] and rdy[i] are both high; an output transfer occurs when out_vld and out_rdy are both high.
REQ-012 Slot free: the output register is free in a cycle when out_vld is low, or when out_vld and out_rdy are both high (same-cycle drain and refill).
REQ-013 Arbitration: when the slot is free and vld is nonzero, the block grants exactly one requester.
- Grant rule: the first set bit of vld, scanning upward from pointer ptr, modulo 4.
- Grant output: rdy is one-hot on the granted requester.
REQ-014 rdy is combinational from vld, ptr and slot state, and is all-zero when the slot is not free or vld is zero.
REQ-015 rdy shall not depend on d0..d3.
REQ-016 On a grant of requester g, at the next edge:
- y takes the payload of g (d0..d3 selected as a 4:1 mux by g);
- sel takes g;
- out_vld goes to 1;
- ptr takes (g+1) mod 4.
REQ-017 Drain without refill: an output transfer with no grant in the same cycle clears out_vld at the next edge; y and sel hold their values.
REQ-018 Stall: while out_vld is 1 and out_rdy is 0, y, sel, out_vld and ptr hold, and rdy is zero.
REQ-019 Idle: when vld is zero, ptr holds.
REQ-020 Latency: an accepted input appears on y exactly one cycle later; sustained throughput is one word per cycle when out_rdy is held high.
REQ-021 Fairness: a requester holding vld high is granted within at most 4 consecutive grants.
REQ-022 The block does not require vld to remain stable while ungranted; each cycle is re-arbitrated.
REQ-023 Pointer arithmetic is 2-bit and wraps from 3 to 0.
REQ-024 X-safety: an X on d of a requester that is not granted shall not propagate to y.

Reset
REQ-025 While rst is high: out_vld = 0, y = 0, sel = 0, ptr = 0, and rdy = 0 regardless of vld.
REQ-026 Mid-operation reset: asserting rst discards any pending output word immediately (asynchronous); no transfer is counted in that cycle.
REQ-027 After rst deasserts, the first grant goes to the lowest-indexed valid requester.

Verification
REQ-028 Reset-then-single request: reset, then vld=4'b0100, d2='hc, out_rdy=1 -> rdy=4'b0100 in that cycle; next cycle y='hc, sel=2, out_vld=1.
REQ-029 All-requesting round-robin: vld=4'b1111, d0..d3='ha,'hb,'hc,'hd, out_rdy=1 for 5 cycles -> y sequence a,b,c,d,a on consecutive cycles; sel sequence 0,1,2,3,0.
REQ-030 Backpressure: the output holds 'ha with out_rdy=0 for 3 cycles and vld=4'b1111 -> rdy=0, and y='ha, sel=0 stay stable; raising out_rdy yields 'hb next cycle (drain and refill in the same cycle).
REQ-031 Skip and wrap: ptr=3 after a grant to 2, then vld=4'b0011 -> grant to 0, then 1; never to 2 or 3.
REQ-032 X isolation: d3='x, vld=4'b0111 -> y never shows X across 6 transfers; values cycle through d0, d1, d2.
REQ-033 Reset mid-stall: out_vld=1 with out_rdy=0, then pulse rst -> out_vld drops without waiting for a clock edge; after release, vld=4'b1010 grants requester 1 first.
